srm_cpu_q: RTL and testbench

- Next-generation Simple RISC Machine multicycle core with a data width parameter, DATA_W (the instruction word stays 16 bits).
- Adds an instruction queue, so `load` can push instructions while an earlier instruction is still executing.
- Status flags update only on CMP.
- Adds ASR to the shifter and a sticky illegal-instruction flag.
- Drop-in successor for the existing cpu, for bench and top-level use.

---
 rtl/srm_pkg.sv | 30 +++
 rtl/srm_iq.sv | 67 ++++++
 rtl/srm_cpu_q.sv | 240 ++++++++++++++++++++++++
 tb/tb_srm_cpu_q.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srm_pkg.sv
// Shared encodings for the queued Simple RISC Machine core: opcodes, ALU ops,
// shifter codes and the FSM state type.
package srm_pkg;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

endpackage

// File: rtl/srm_iq.sv
// Instruction queue: synchronous show-ahead FIFO. dout always shows the oldest
// entry; a push while full is dropped even if a pop happens in the same cycle.
module srm_iq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/srm_cpu_q.sv
// Multicycle Simple RISC Machine core with an instruction queue in front of the
// FSM; flags change only on CMP and undefined encodings raise a sticky flag.
module srm_cpu_q
    import srm_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int IQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [15:0]       in,
    output logic              full,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              illegal
);

    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic              n_q, n_d, v_q, v_d, z_q, z_d;
    logic              illegal_q, illegal_d;

    logic              pop, empty;
    logic [15:0]       iq_dout;

    logic [2:0]        opcode, rn, rd, rm;
    logic [1:0]        op, sh;
    logic [DATA_W-1:0] imm_sx;
    logic              is_mov_imm, is_mov_reg, is_alu;

    logic              reg_we;
    logic [2:0]        reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] rd_a, rd_b;

    logic [DATA_W-1:0] b_sh, diff, alu_out;

    srm_iq #(
        .WIDTH(16),
        .DEPTH(IQ_DEPTH)
    ) u_iq (
        .clk  (clk),
        .rst_n(reset),
        .push (load),
        .pop  (pop),
        .din  (in),
        .dout (iq_dout),
        .full (full),
        .empty(empty)
    );

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign imm_sx = {{(DATA_W - 8){ir_q[7]}}, ir_q[7:0]};

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);

    // Register file lives under DP.REGFILE so R0..R7 keep stable hierarchical names.
    if (1) begin : DP
        if (1) begin : REGFILE
            logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
                    R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
                end else if (reg_we) begin
                    case (reg_waddr)
                        3'd0: R0 <= reg_wdata;
                        3'd1: R1 <= reg_wdata;
                        3'd2: R2 <= reg_wdata;
                        3'd3: R3 <= reg_wdata;
                        3'd4: R4 <= reg_wdata;
                        3'd5: R5 <= reg_wdata;
                        3'd6: R6 <= reg_wdata;
                        default: R7 <= reg_wdata;
                    endcase
                end
            end

            always_comb begin
                rd_a = R0;
                case (rn)
                    3'd1: rd_a = R1;
                    3'd2: rd_a = R2;
                    3'd3: rd_a = R3;
                    3'd4: rd_a = R4;
                    3'd5: rd_a = R5;
                    3'd6: rd_a = R6;
                    3'd7: rd_a = R7;
                    default: rd_a = R0;
                endcase
                rd_b = R0;
                case (rm)
                    3'd1: rd_b = R1;
                    3'd2: rd_b = R2;
                    3'd3: rd_b = R3;
                    3'd4: rd_b = R4;
                    3'd5: rd_b = R5;
                    3'd6: rd_b = R6;
                    3'd7: rd_b = R7;
                    default: rd_b = R0;
                endcase
            end
        end
    end

    always_comb begin
        case (sh)
            SH_NONE: b_sh = b_q;
            SH_LSL:  b_sh = {b_q[MSB-1:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[MSB:1]};
            SH_ASR:  b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
        diff = a_q - b_sh;
        case (op)
            OP_ADD:  alu_out = a_q + b_sh;
            OP_CMP:  alu_out = diff;
            OP_AND:  alu_out = a_q & b_sh;
            OP_MVN:  alu_out = ~b_sh;
            default: alu_out = a_q + b_sh;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        n_d       = n_q;
        v_d       = v_q;
        z_d       = z_q;
        illegal_d = illegal_q;
        pop       = 1'b0;
        reg_we    = 1'b0;
        reg_waddr = rd;
        reg_wdata = c_q;
        case (state_q)
            S_WAIT: begin
                if (!empty) begin
                    pop     = 1'b1;
                    ir_d    = iq_dout;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg || (is_alu && op == OP_MVN)) begin
                    a_d     = '0;
                    state_d = S_GET_B;
                end else if (is_alu) begin
                    state_d = S_GET_A;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WR_IMM: begin
                reg_we    = 1'b1;
                reg_waddr = rn;
                reg_wdata = imm_sx;
                c_d       = imm_sx;
                state_d   = S_WAIT;
            end
            S_GET_A: begin
                a_d     = rd_a;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                b_d     = rd_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu && op == OP_CMP) begin
                    // Signed overflow: operands differ in sign and result sign differs from A.
                    n_d     = diff[MSB];
                    z_d     = (diff == '0);
                    v_d     = (a_q[MSB] ^ b_sh[MSB]) & (diff[MSB] ^ a_q[MSB]);
                    state_d = S_WAIT;
                end else begin
                    c_d     = alu_out;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                reg_we  = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_WAIT;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            n_q       <= n_d;
            v_q       <= v_d;
            z_q       <= z_d;
            illegal_q <= illegal_d;
        end
    end

    assign out     = c_q;
    assign N       = n_q;
    assign V       = v_q;
    assign Z       = z_q;
    assign illegal = illegal_q;
    assign w       = (state_q == S_WAIT) && empty;

endmodule

// File: tb/tb_srm_cpu_q.sv
// Directed bench for srm_cpu_q: three widths (16, 32, 9) share one instruction
// stream and run in lockstep, since timing does not depend on DATA_W.
module tb_srm_cpu_q;
    import srm_pkg::*;

    logic        clk, reset, load;
    logic [15:0] in;

    logic        full16, full32, full9;
    logic [15:0] out16;
    logic [31:0] out32;
    logic [8:0]  out9;
    logic        n16, v16, z16, w16, ill16;
    logic        n32, v32, z32, w32, ill32;
    logic        n9, v9, z9, w9, ill9;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] r16 [8];

    srm_cpu_q #(.DATA_W(16), .IQ_DEPTH(4)) dut16 (
        .clk(clk), .reset(reset), .load(load), .in(in), .full(full16), .out(out16),
        .N(n16), .V(v16), .Z(z16), .w(w16), .illegal(ill16)
    );
    srm_cpu_q #(.DATA_W(32), .IQ_DEPTH(4)) dut32 (
        .clk(clk), .reset(reset), .load(load), .in(in), .full(full32), .out(out32),
        .N(n32), .V(v32), .Z(z32), .w(w32), .illegal(ill32)
    );
    srm_cpu_q #(.DATA_W(9), .IQ_DEPTH(4)) dut9 (
        .clk(clk), .reset(reset), .load(load), .in(in), .full(full9), .out(out9),
        .N(n9), .V(v9), .Z(z9), .w(w9), .illegal(ill9)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        reset = 1'b0;
        load  = 1'b1;
        in    = 16'hD7FF;
        repeat (2) @(posedge clk);
        #1;
        load  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic load_word(input logic [15:0] word);
        load = 1'b1;
        in   = word;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!w16 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (w16 !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: w=%b required 1 within %0d cycles", name, w16, n);
        end
    endtask

    task automatic snap16();
        r16[0] = dut16.DP.REGFILE.R0;
        r16[1] = dut16.DP.REGFILE.R1;
        r16[2] = dut16.DP.REGFILE.R2;
        r16[3] = dut16.DP.REGFILE.R3;
        r16[4] = dut16.DP.REGFILE.R4;
        r16[5] = dut16.DP.REGFILE.R5;
        r16[6] = dut16.DP.REGFILE.R6;
        r16[7] = dut16.DP.REGFILE.R7;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        snap16();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r16[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_R%0d: got %h required 0000", i, r16[i]);
            end
        end
        checks++;
        if ({w16, full16, ill16, n16, v16, z16} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_status: w,full,ill,N,V,Z=%b required 100000",
                     {w16, full16, ill16, n16, v16, z16});
        end
        checks++;
        if (out16 !== 16'h0 || out32 !== 32'h0 || out9 !== 9'h0) begin
            errors++;
            $display("FAIL reset_out: got %h/%h/%h required 0", out16, out32, out9);
        end
    endtask

    task automatic test_back_to_back();
        int   rises = 0;
        logic prev;
        load_word(16'hD007);
        load_word(16'hD102);
        load_word(16'hA148);
        prev = w16;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (w16 === 1'b1 && prev !== 1'b1) rises++;
            prev = w16;
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL b2b_w_rises: got %0d required 1", rises);
        end
        snap16();
        checks++;
        if (r16[0] !== 16'h0007 || r16[1] !== 16'h0002 || r16[2] !== 16'h0010) begin
            errors++;
            $display("FAIL b2b_regs: R0,R1,R2=%h,%h,%h required 0007,0002,0010", r16[0], r16[1], r16[2]);
        end
        checks++;
        if (out16 !== 16'h0010 || w16 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_out: out=%h w=%b required 0010 1", out16, w16);
        end
    endtask

    task automatic test_shift();
        load_word(16'hD3FF);
        load_word(16'hC093);
        load_word(16'hC0BB);
        wait_idle("shift");
        checks++;
        if (dut32.DP.REGFILE.R3 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL shift_mov_neg32: got %h required ffffffff", dut32.DP.REGFILE.R3);
        end
        checks++;
        if (dut32.DP.REGFILE.R4 !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL shift_lsr32: got %h required 7fffffff", dut32.DP.REGFILE.R4);
        end
        checks++;
        if (dut32.DP.REGFILE.R5 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL shift_asr32: got %h required ffffffff", dut32.DP.REGFILE.R5);
        end
        checks++;
        if (dut16.DP.REGFILE.R4 !== 16'h7FFF || dut9.DP.REGFILE.R4 !== 9'h0FF) begin
            errors++;
            $display("FAIL shift_lsr_narrow: got %h/%h required 7fff/0ff",
                     dut16.DP.REGFILE.R4, dut9.DP.REGFILE.R4);
        end
    endtask

    task automatic test_flags();
        load_word(16'hD004);
        load_word(16'hD102);
        load_word(16'hA900);
        wait_idle("cmp_neg");
        checks++;
        if ({n16, z16, v16} !== 3'b100) begin
            errors++;
            $display("FAIL cmp_neg: N,Z,V=%b required 100", {n16, z16, v16});
        end
        load_word(16'hA800);
        wait_idle("cmp_eq");
        checks++;
        if ({n16, z16, v16} !== 3'b010) begin
            errors++;
            $display("FAIL cmp_eq: N,Z,V=%b required 010", {n16, z16, v16});
        end
        load_word(16'hA140);
        wait_idle("add_keeps_flags");
        checks++;
        if ({n16, z16, v16} !== 3'b010 || dut16.DP.REGFILE.R2 !== 16'h0006) begin
            errors++;
            $display("FAIL add_keeps_flags: N,Z,V=%b R2=%h required 010 0006",
                     {n16, z16, v16}, dut16.DP.REGFILE.R2);
        end
        load_word(16'hD080);
        load_word(16'hD17F);
        load_word(16'hA809);
        wait_idle("cmp_ovf");
        checks++;
        if ({n9, z9, v9} !== 3'b001) begin
            errors++;
            $display("FAIL cmp_ovf9: N,Z,V=%b required 001", {n9, z9, v9});
        end
        checks++;
        if ({n16, z16, v16} !== 3'b100) begin
            errors++;
            $display("FAIL cmp_noovf16: N,Z,V=%b required 100", {n16, z16, v16});
        end
    endtask

    task automatic test_queue_full();
        logic [15:0] words [6];
        logic [15:0] exp_r [8];
        words = '{16'hD001, 16'hD102, 16'hD203, 16'hD304, 16'hD405, 16'hD506};
        exp_r = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'h0055};
        do_reset();
        load_word(16'hD755);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                checks++;
                if (full16 !== 1'b0) begin
                    errors++;
                    $display("FAIL qfull_before_5th: full=%b required 0", full16);
                end
            end
            if (i == 5) begin
                checks++;
                if (full16 !== 1'b1) begin
                    errors++;
                    $display("FAIL qfull_at_6th: full=%b required 1", full16);
                end
            end
            load_word(words[i]);
        end
        wait_idle("qfull");
        snap16();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r16[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL qfull_R%0d: got %h required %h", i, r16[i], exp_r[i]);
            end
        end
        checks++;
        if (full16 !== 1'b0) begin
            errors++;
            $display("FAIL qfull_drained: full=%b required 0", full16);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp_r [8];
        exp_r = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'h0055};
        load_word(16'h0000);
        wait_idle("illegal");
        checks++;
        if (ill16 !== 1'b1) begin
            errors++;
            $display("FAIL illegal_set: got %b required 1", ill16);
        end
        snap16();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r16[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL illegal_R%0d: got %h required %h", i, r16[i], exp_r[i]);
            end
        end
        checks++;
        if (out16 !== 16'h0005 || {n16, z16, v16} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_side_effect: out=%h NZV=%b required 0005 000", out16, {n16, z16, v16});
        end
        load_word(16'hD609);
        wait_idle("after_illegal");
        checks++;
        if (dut16.DP.REGFILE.R6 !== 16'h0009 || ill16 !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: R6=%h illegal=%b required 0009 1", dut16.DP.REGFILE.R6, ill16);
        end
    endtask

    task automatic test_reset_mid();
        load_word(16'hD003);
        load_word(16'hD104);
        wait_idle("pre_reset_mid");
        load_word(16'hA148);
        load_word(16'hD711);
        load_word(16'hD622);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (dut16.state_q !== S_EXEC) begin
            errors++;
            $display("FAIL reset_mid_in_exec: state=%0d required %0d", dut16.state_q, S_EXEC);
        end
        reset = 1'b0;
        #2;
        snap16();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r16[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_mid_R%0d: got %h required 0000", i, r16[i]);
            end
        end
        checks++;
        if ({w16, full16, ill16, n16, v16, z16} !== 6'b100000 || out16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_status: w,full,ill,N,V,Z=%b out=%h required 100000 0000",
                     {w16, full16, ill16, n16, v16, z16}, out16);
        end
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (dut16.DP.REGFILE.R2 !== 16'h0 || dut16.DP.REGFILE.R6 !== 16'h0 ||
            dut16.DP.REGFILE.R7 !== 16'h0 || w16 !== 1'b1 || out16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_no_replay: R2,R6,R7=%h,%h,%h w=%b out=%h required 0,0,0 1 0",
                     dut16.DP.REGFILE.R2, dut16.DP.REGFILE.R6, dut16.DP.REGFILE.R7, w16, out16);
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        in    = 16'h0;
        #1;
        test_reset();
        test_back_to_back();
        test_shift();
        test_flags();
        test_queue_full();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
